// File: rtl/gpio_pwm_pkg.sv
// Shared definitions for the PWM waveform sequencer: state encoding, table entry layout, channel control codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gpio_pwm_pkg;

  // Sequencer states; the encoding is visible to the register bank for debug reads.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  // Table entry layout: [31:20] high ticks, [19:8] low ticks, [7:0] extra repeats.
  localparam int HOUT_MSB = 31;
  localparam int HOUT_LSB = 20;
  localparam int LOUT_MSB = 19;
  localparam int LOUT_LSB = 8;
  localparam int REPS_MSB = 7;
  localparam int REPS_LSB = 0;

  // gpio_pwm channel control codes.
  localparam logic [1:0] PWM_CTRL_OFF  = 2'd0;
  localparam logic [1:0] PWM_CTRL_CONT = 2'd3;

  // Value of the per-period tick counter on the tick that closes a period.
  // The sum is 13 bits so two full-scale 12-bit fields cannot wrap; an empty
  // period (both fields zero) still lasts one tick.
  function automatic logic [12:0] period_last(input logic [11:0] hout,
                                              input logic [11:0] lout);
    logic [12:0] len;
    len = {1'b0, hout} + {1'b0, lout};
    return (len == 13'd0) ? 13'd0 : (len - 13'd1);
  endfunction

endpackage

// File: rtl/gpio_pwm_seq_ram.sv
// Waveform table: DEPTH x 32 storage with a synchronous write port and a registered read port.
// Latency: write visible one cycle after wr_en; rd_data updates one cycle after rd_en.
// Backpressure: none; writes are accepted every cycle, rd_data holds while rd_en is low.
module gpio_pwm_seq_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  // Table storage is deliberately left unreset so firmware contents survive only by rewrite.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register doubles as the channel's hout/lout source, so it holds between reads.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/gpio_pwm_seq.sv
// Plays a table of (hout, lout, reps) PWM entries into one gpio_pwm channel, advancing on period ends.
// Latency: start -> LOAD next cycle -> channel enabled one cycle later; entry switch costs one LOAD cycle.
// Backpressure: none; ticks outside RUN and start while busy are dropped. Optional IRQ: GPIO_PWM_SEQ_IRQ_EN.
module gpio_pwm_seq
  import gpio_pwm_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          tick,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] seq_last,
  input  logic          loop_en,
  input  logic          start,
  input  logic          abort,
  output logic [11:0]   pwm_hout,
  output logic [11:0]   pwm_lout,
  output logic [1:0]    pwm_ctrl,
  output logic          busy,
  output logic [AW-1:0] cur_idx,
  output logic          done
`ifdef GPIO_PWM_SEQ_IRQ_EN
  ,
  output logic          irq,
  input  logic          irq_clr
`endif
);

  seq_state_t    state_q, state_nxt;
  logic [AW-1:0] idx_q, idx_nxt;
  logic [AW-1:0] last_q, last_nxt;
  logic [12:0]   per_q, per_nxt;
  logic [12:0]   per_last;
  logic [7:0]    rep_q, rep_nxt;
  logic [7:0]    reps;
  logic [1:0]    ctrl_q, ctrl_nxt;
  logic          rd_en;
  logic [31:0]   rd_data;

  gpio_pwm_seq_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset_l (reset_l),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (idx_q),
    .rd_data (rd_data)
  );

  // The read register holds the entry being played, so the channel fields come straight from it.
  assign pwm_hout = rd_data[HOUT_MSB:HOUT_LSB];
  assign pwm_lout = rd_data[LOUT_MSB:LOUT_LSB];
  assign reps     = rd_data[REPS_MSB:REPS_LSB];
  assign per_last = period_last(pwm_hout, pwm_lout);

  assign pwm_ctrl = ctrl_q;
  assign busy     = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign cur_idx  = idx_q;

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      per_q   <= '0;
      rep_q   <= '0;
      ctrl_q  <= PWM_CTRL_OFF;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      last_q  <= last_nxt;
      per_q   <= per_nxt;
      rep_q   <= rep_nxt;
      ctrl_q  <= ctrl_nxt;
    end
  end

  // Next-state logic. rep_q counts periods already finished for the current
  // entry; the entry is complete when it has played reps+1 periods.
  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    last_nxt  = last_q;
    per_nxt   = per_q;
    rep_nxt   = rep_q;
    rd_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_LOAD;
          idx_nxt   = '0;
          last_nxt  = seq_last;
        end
      end
      ST_LOAD: begin
        rd_en     = 1'b1;
        per_nxt   = '0;
        rep_nxt   = '0;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (tick) begin
          if (per_q == per_last) begin
            per_nxt = '0;
            if (rep_q != reps) begin
              rep_nxt = rep_q + 8'd1;
            end else if (idx_q != last_q) begin
              idx_nxt   = idx_q + AW'(1);
              state_nxt = ST_LOAD;
            end else if (loop_en) begin
              idx_nxt   = '0;
              state_nxt = ST_LOAD;
            end else begin
              state_nxt = ST_DONE;
            end
          end else begin
            per_nxt = per_q + 13'd1;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including a same-cycle start or period end,
    // and leaves the playing entry's fields and index untouched.
    if (abort) begin
      state_nxt = ST_IDLE;
      idx_nxt   = idx_q;
      last_nxt  = last_q;
      per_nxt   = per_q;
      rep_nxt   = rep_q;
      rd_en     = 1'b0;
    end

    // Channel stays enabled across LOAD so back-to-back entries do not glitch it off.
    case (state_nxt)
      ST_RUN:  ctrl_nxt = PWM_CTRL_CONT;
      ST_LOAD: ctrl_nxt = ctrl_q;
      default: ctrl_nxt = PWM_CTRL_OFF;
    endcase
  end

`ifdef GPIO_PWM_SEQ_IRQ_EN
  logic irq_set;
  logic irq_q;

  // Raise on normal completion or on a wrap back to entry 0 (a RUN->LOAD move from the last index).
  assign irq_set = (state_q == ST_RUN) &&
                   ((state_nxt == ST_DONE) ||
                    ((state_nxt == ST_LOAD) && (idx_q == last_q)));

  // Sticky interrupt flag; a set in the same cycle as a clear keeps it high.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      irq_q <= 1'b0;
    end else if (irq_set) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_gpio_pwm_seq.sv
// Randomized self-checking bench for gpio_pwm_seq against a per-entry tick-budget reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_gpio_pwm_seq;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int MAXC  = 4400;

  logic          clk = 1'b0;
  logic          reset_l;
  logic          tick, wr_en, loop_en, start, abort;
  logic [AW-1:0] wr_addr, seq_last;
  logic [31:0]   wr_data;
  logic [11:0]   pwm_hout, pwm_lout;
  logic [1:0]    pwm_ctrl;
  logic          busy, done;
  logic [AW-1:0] cur_idx;
`ifdef GPIO_PWM_SEQ_IRQ_EN
  logic          irq;
  logic          irq_clr;
`endif

  gpio_pwm_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .reset_l  (reset_l),
    .tick     (tick),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .seq_last (seq_last),
    .loop_en  (loop_en),
    .start    (start),
    .abort    (abort),
    .pwm_hout (pwm_hout),
    .pwm_lout (pwm_lout),
    .pwm_ctrl (pwm_ctrl),
    .busy     (busy),
    .cur_idx  (cur_idx),
    .done     (done)
`ifdef GPIO_PWM_SEQ_IRQ_EN
    ,
    .irq      (irq),
    .irq_clr  (irq_clr)
`endif
  );

  always #5 clk = ~clk;

  // Reference state: table image, per-cycle tick pattern and expected outputs.
  logic [31:0]   tbl    [DEPTH];
  bit            tick_pat [MAXC];
  logic          e_busy [MAXC];
  logic [1:0]    e_ctrl [MAXC];
  logic [AW-1:0] e_idx  [MAXC];
  logic [11:0]   e_hout [MAXC];
  logic [11:0]   e_lout [MAXC];
  logic          e_done [MAXC];
  logic [11:0]   m_hout, m_lout;
  int            n_chk, n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic put(input int c, input logic b, input logic [1:0] ct, input int i,
                     input logic [11:0] h, input logic [11:0] l, input logic d);
    if (c < MAXC) begin
      e_busy[c] = b;
      e_ctrl[c] = ct;
      e_idx[c]  = AW'(i);
      e_hout[c] = h;
      e_lout[c] = l;
      e_done[c] = d;
    end
  endtask

  // Cycle 0 carries start. Each visited entry costs one LOAD cycle plus enough
  // RUN cycles to consume (reps+1)*max(hout+lout,1) ticks.
  task automatic predict(input int slast, input bit lp, input int wr_at, input int wr_a,
                         input logic [31:0] wr_d, output int end_c);
    int c, i, need, plen;
    logic [31:0] e;
    logic [1:0]  ct;
    logic [11:0] h, l;
    c = 1; i = 0; ct = 2'd0; h = m_hout; l = m_lout;
    end_c = MAXC - 3;
    for (int k = 0; k < MAXC; k++) put(k, 1'b0, 2'd0, 0, h, l, 1'b0);
    while (c < MAXC) begin
      put(c, 1'b1, ct, i, h, l, 1'b0);
      e = (wr_at > 0 && c > wr_at && wr_a == i) ? wr_d : tbl[i];
      c++;
      h = e[31:20]; l = e[19:8]; ct = 2'd3;
      plen = int'(h) + int'(l);
      if (plen == 0) plen = 1;
      need = (int'(e[7:0]) + 1) * plen;
      while (need > 0 && c < MAXC) begin
        put(c, 1'b1, 2'd3, i, h, l, 1'b0);
        if (tick_pat[c]) need--;
        c++;
      end
      if (need > 0) break;
      if (i != slast) i++;
      else if (lp) i = 0;
      else begin
        put(c, 1'b0, 2'd0, i, h, l, 1'b1);
        end_c = c;
        for (int k = c + 1; k < MAXC; k++) put(k, 1'b0, 2'd0, i, h, l, 1'b0);
        break;
      end
    end
    if (end_c > MAXC - 3) end_c = MAXC - 3;
  endtask

  task automatic run(input int slast, input bit lp, input int abort_at, input int wr_at,
                     input int wr_a, input logic [31:0] wr_d, input int prob, input bit stray);
    int end_c, ncyc;
    for (int k = 0; k < MAXC; k++) tick_pat[k] = ($urandom_range(99) < prob);
    predict(slast, lp, wr_at, wr_a, wr_d, end_c);
    if (abort_at > 0) begin
      for (int c = abort_at + 1; c < MAXC; c++)
        put(c, 1'b0, 2'd0, int'(e_idx[abort_at]), e_hout[abort_at], e_lout[abort_at], 1'b0);
      ncyc = abort_at + 2;
    end else begin
      ncyc = end_c + 2;
    end
    @(posedge clk); #1;
    start = 1'b1; seq_last = AW'(slast); loop_en = lp; tick = tick_pat[0];
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      start   = (stray && e_busy[k] && ($urandom_range(9) == 0)) || (k == abort_at);
      abort   = (k == abort_at);
      tick    = tick_pat[k];
      wr_en   = (k == wr_at);
      wr_addr = AW'(wr_a);
      wr_data = wr_d;
      @(negedge clk);
      check_eq($sformatf("busy@%0d", k), busy, e_busy[k]);
      check_eq($sformatf("ctrl@%0d", k), pwm_ctrl, e_ctrl[k]);
      check_eq($sformatf("idx@%0d", k), cur_idx, e_idx[k]);
      check_eq($sformatf("hout@%0d", k), pwm_hout, e_hout[k]);
      check_eq($sformatf("lout@%0d", k), pwm_lout, e_lout[k]);
      check_eq($sformatf("done@%0d", k), done, e_done[k]);
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; tick = 1'b0; wr_en = 1'b0;
    if (wr_at > 0 && wr_at <= ncyc) tbl[wr_a] = wr_d;
    m_hout = e_hout[ncyc];
    m_lout = e_lout[ncyc];
  endtask

  task automatic write_entry(input int a, input int h, input int l, input int r);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = {12'(h), 12'(l), 8'(r)};
    @(posedge clk); #1;
    wr_en = 1'b0;
    tbl[a] = {12'(h), 12'(l), 8'(r)};
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_hout"}, pwm_hout, 0);
    check_eq({tag, "_lout"}, pwm_lout, 0);
    check_eq({tag, "_ctrl"}, pwm_ctrl, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_idx"},  cur_idx, 0);
    check_eq({tag, "_done"}, done, 0);
  endtask

`ifdef GPIO_PWM_SEQ_IRQ_EN
  task automatic irq_check_clear(input string tag);
    check_eq({tag, "_set"}, irq, 1);
    @(posedge clk); #1 irq_clr = 1'b1;
    @(posedge clk); #1 irq_clr = 1'b0;
    check_eq({tag, "_clr"}, irq, 0);
  endtask
`endif

  initial begin
    n_chk = 0; n_fail = 0;
    reset_l = 1'b1;
    tick = 0; wr_en = 0; loop_en = 0; start = 0; abort = 0;
    wr_addr = '0; seq_last = '0; wr_data = '0;
`ifdef GPIO_PWM_SEQ_IRQ_EN
    irq_clr = 1'b0;
`endif
    m_hout = '0; m_lout = '0;
    for (int i = 0; i < DEPTH; i++) tbl[i] = '0;
    #1 reset_l = 1'b0;
    #2 check_idle_zero("rst");
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_entry(i, 0, 0, 0);

    // Two entries, single pass, tick every cycle.
    write_entry(0, 2, 3, 1);
    write_entry(1, 1, 1, 0);
    run(1, 1'b0, 0, 0, 0, 32'h0, 100, 1'b0);
`ifdef GPIO_PWM_SEQ_IRQ_EN
    irq_check_clear("irq_done");
`endif

    // Loop wrap, then abort together with start.
    run(1, 1'b1, 30, 0, 0, 32'h0, 100, 1'b0);
`ifdef GPIO_PWM_SEQ_IRQ_EN
    irq_check_clear("irq_wrap");
`endif

    // Restart after abort; stray starts while busy must be ignored.
    run(1, 1'b0, 0, 0, 0, 32'h0, 100, 1'b1);

    // Rewrite entry 1 while entry 0 plays.
    run(1, 1'b0, 0, 4, 1, {12'd3, 12'd2, 8'd0}, 100, 1'b0);

    // Empty periods last one tick each.
    write_entry(0, 0, 0, 2);
    run(0, 1'b0, 0, 0, 0, 32'h0, 100, 1'b0);

    // 13-bit period length: 0xFFF + 1 must not wrap to zero.
    write_entry(0, 12'hFFF, 1, 0);
    run(0, 1'b0, 0, 0, 0, 32'h0, 100, 1'b0);

    // Asynchronous reset in mid-RUN.
    write_entry(0, 2, 3, 1);
    @(posedge clk); #1 start = 1'b1; seq_last = AW'(1); loop_en = 1'b0; tick = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #2 reset_l = 1'b0;
    #1 check_idle_zero("arst");
    @(posedge clk); #2 check_eq("arst_hold_busy", busy, 0);
    @(negedge clk); reset_l = 1'b1; tick = 1'b0;
    @(negedge clk);
    check_idle_zero("arst_rel");
    m_hout = '0; m_lout = '0;
    run(1, 1'b0, 0, 0, 0, 32'h0, 100, 1'b0);

    // Randomized tables, tick density, loop/abort and mid-run writes.
    for (int r = 0; r < 10; r++) begin
      int sl, ab, wa;
      bit lp;
      for (int i = 0; i < DEPTH; i++)
        write_entry(i, $urandom_range(3), $urandom_range(3), $urandom_range(3));
      sl = $urandom_range(DEPTH - 1);
      lp = $urandom_range(1);
      if (lp) ab = $urandom_range(300, 10);
      else    ab = ($urandom_range(3) == 0) ? $urandom_range(60, 2) : 0;
      wa = $urandom_range(DEPTH - 1);
      run(sl, lp, ab, $urandom_range(20, 1), wa,
          {12'($urandom_range(3)), 12'($urandom_range(3)), 8'($urandom_range(3))},
          $urandom_range(100, 30), 1'b1);
`ifdef GPIO_PWM_SEQ_IRQ_EN
      @(posedge clk); #1 irq_clr = 1'b1;
      @(posedge clk); #1 irq_clr = 1'b0;
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_pwm_seq.md
Name: gpio_pwm_seq

Overview:
Sequencer that plays a host-loaded table of PWM waveforms into one gpio_pwm channel. Each entry holds high time, low time and a repeat count. The block drives the channel's pwm_hout/pwm_lout/pwm_ctrl, and tracks period boundaries from the shared prescale tick so that it can advance entries. It sits between the GPIO register bank and gpio_pwm, so firmware no longer has to rewrite the PWM registers for every period.

Parameters:
DEPTH, 16, number of table entries (power of two, 2..256)
AW, 4, address width, equal to log2(DEPTH)

Ports:
clk  in  1  system clock
reset_l  in  1  asynchronous active-low reset
tick  in  1  prescale tick; one-cycle pulse from the shared prescaler
wr_en  in  1  table write strobe
wr_addr  in  AW  table write index
wr_data  in  32  entry: [31:20] hout, [19:8] lout, [7:0] reps
seq_last  in  AW  index of the last entry to play
loop_en  in  1  1 = wrap to entry 0 after seq_last
start  in  1  one-cycle start pulse
abort  in  1  one-cycle abort pulse
pwm_hout  out  12  high ticks sent to the PWM channel
pwm_lout  out  12  low ticks sent to the PWM channel
pwm_ctrl  out  2  0 = off, 3 = continuous
busy  out  1  high in LOAD or RUN
cur_idx  out  AW  entry currently playing
done  out  1  one-cycle pulse at normal completion

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are named clk and reset_l.
- Reset values: every output is 0; the state is IDLE. The table contents are not reset.
- Table: a DEPTH x 32 register array. A write lands one cycle after wr_en. Writes are accepted in every state. A write to an entry takes effect the next time that entry is loaded.
- State machine states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - pwm_ctrl = 0.
  - start moves to LOAD with idx = 0.
- LOAD (exactly 1 cycle):
  - Registered read of table[idx] into pwm_hout, pwm_lout and rep_cnt.
  - per_cnt is cleared.
  - Next state is RUN, with pwm_ctrl = 3 from the first RUN cycle.
- RUN, per-tick counting:
  - On each tick, per_cnt increments.
  - period_len = hout + lout, computed 13 bits wide. A period_len of 0 is treated as 1.
  - The period ends on the tick where per_cnt == period_len-1. At that tick per_cnt is cleared.
- RUN, at the end of a period:
  - If rep_cnt != 0, rep_cnt decrements and the same entry plays again. reps = N gives N+1 periods.
  - Otherwise, if idx != seq_last: idx increments and the state goes to LOAD.
  - Otherwise, if loop_en: idx = 0 and the state goes to LOAD.
  - Otherwise the state goes to DONE.
- Ticks arriving in non-RUN states are ignored. While in LOAD, pwm_ctrl holds its previous value. Back-to-back entries therefore keep pwm_ctrl = 3 across the LOAD cycle.
- DONE (1 cycle): pwm_ctrl = 0 and done = 1, then IDLE.
- abort: from any state, the next state is IDLE with pwm_ctrl = 0 and no done pulse. abort wins over a simultaneous start or period end.
- start while busy is ignored.
- seq_last is sampled at start. If seq_last > DEPTH-1, the value is clipped by AW truncation.
- pwm_hout and pwm_lout hold their last value in IDLE.
- cur_idx = idx; it holds after completion.

Optional Feature:
GPIO_PWM_SEQ_IRQ_EN
- When defined, adds ports irq (out, 1) and irq_clr (in, 1).
- irq is set by done or by loop wrap and is sticky until irq_clr. If set and clear occur in the same cycle, set wins.
- When not defined, neither port exists and there is no added logic.

Decomposition:
- Shared package gpio_pwm_pkg holds:
  - state encoding (IDLE=0, LOAD=1, RUN=2, DONE=3)
  - entry field positions (HOUT_MSB/LSB, LOUT_MSB/LSB, REPS_MSB/LSB)
  - PWM_CTRL_OFF=2'd0 and PWM_CTRL_CONT=2'd3
- One natural sub-module, gpio_pwm_seq_ram: the DEPTH x 32 table with a synchronous write port and a registered read port.

Test Plan:
- Play two entries: load entry 0 = (hout 2, lout 3, reps 1) and entry 1 = (1, 1, 0); seq_last = 1, loop_en = 0, tick every cycle, start. Required: pwm_ctrl = 3 for 10+2 ticks plus the LOAD cycles, cur_idx goes 0 then 1, then one done pulse, and pwm_ctrl returns to 0.
- Loop wrap: same table with loop_en = 1. Required: cur_idx sequence 0,0,1,0,... and no done pulse. With the IRQ macro, irq rises at the wrap.
- Zero-length period: entry (0, 0, 2), seq_last = 0. Required: 3 periods of 1 tick each, then done.
- Abort: abort in mid-RUN together with a simultaneous start. Required: IDLE the next cycle, pwm_ctrl = 0, busy = 0, no done pulse. A later start restarts from idx 0.
- Write during RUN: rewrite entry 1 while entry 0 is playing. Required: the new values appear on pwm_hout/pwm_lout at the LOAD of entry 1.
- Reset in mid-RUN: assert reset_l = 0 asynchronously during RUN. Required: all outputs are 0 immediately, and after release the block is in IDLE.
